// File: rtl/regfile_wport_arb.sv
// regfile_wport_arb: shares the register file's single write port between the
// writeback stage (port A) and the multiply/divide unit (port B). B results are
// buffered in a 2-entry FIFO; a starvation counter forces B to drain.
// Optional feature macro: REGFILE_ARB_SCOREBOARD_EN (enables pending_mask).
//
// Handshakes: a transfer on a port happens on a rising edge where valid & ready
// are both high. ready depends only on registered state and a_valid, never on
// b_valid. A null write (resolved address 0) is accepted and discarded.
module regfile_wport_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [1:0]  a_RegDst,
  input  logic [4:0]  a_rb,
  input  logic [4:0]  a_rc,
  input  logic [31:0] a_wdata,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [1:0]  b_RegDst,
  input  logic [4:0]  b_rb,
  input  logic [4:0]  b_rc,
  input  logic [31:0] b_wdata,
  output logic        rf_RegWrite,
  output logic [1:0]  rf_RegDst,
  output logic [4:0]  rf_rc,
  output logic [31:0] rf_wdata,
  output logic [31:0] pending_mask
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // FIFO is a 2-deep shift register: entry 0 is always the head (oldest).
  logic [1:0]  cnt_q, cnt_d;
  logic [4:0]  e0_addr_q, e0_addr_d, e1_addr_q, e1_addr_d;
  logic [31:0] e0_data_q, e0_data_d, e1_data_q, e1_data_d;
  logic [3:0]  starve_q, starve_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_rc_q, rf_rc_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;

  logic        fifo_empty, pop, push;
  logic [4:0]  a_addr, b_addr;

  function automatic logic [4:0] resolve(input logic [1:0] dst,
                                         input logic [4:0] rb,
                                         input logic [4:0] rc);
    case (dst)
      2'b00:   resolve = rc;
      2'b01:   resolve = rb;
      2'b10:   resolve = 5'd31;
      default: resolve = 5'd1;
    endcase
  endfunction

  // Arbitration, FIFO bookkeeping and next write-port values.
  always_comb begin
    cnt_d      = cnt_q;
    e0_addr_d  = e0_addr_q;
    e0_data_d  = e0_data_q;
    e1_addr_d  = e1_addr_q;
    e1_data_d  = e1_data_q;
    starve_d   = starve_q;
    rf_we_d    = 1'b0;
    rf_rc_d    = 5'd0;
    rf_wdata_d = 32'd0;

    a_addr     = resolve(a_RegDst, a_rb, a_rc);
    b_addr     = resolve(b_RegDst, b_rb, b_rc);
    fifo_empty = (cnt_q == 2'd0);
    pop        = !fifo_empty && ((starve_q == LIMIT) || !a_valid);
    a_ready    = !pop;
    b_ready    = (cnt_q != 2'd2);
    push       = b_valid && b_ready && (b_addr != 5'd0);

    if (pop) begin
      rf_we_d    = 1'b1;
      rf_rc_d    = e0_addr_q;
      rf_wdata_d = e0_data_q;
    end else if (a_valid && (a_addr != 5'd0)) begin
      rf_we_d    = 1'b1;
      rf_rc_d    = a_addr;
      rf_wdata_d = a_wdata;
    end

    // Count only A grants made while B is waiting.
    if (pop || fifo_empty) begin
      starve_d = 4'd0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + 4'd1;
    end

    case ({push, pop})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (fifo_empty) begin
          e0_addr_d = b_addr;
          e0_data_d = b_wdata;
        end else begin
          e1_addr_d = b_addr;
          e1_data_d = b_wdata;
        end
      end
      2'b01: begin
        cnt_d     = cnt_q - 2'd1;
        e0_addr_d = e1_addr_q;
        e0_data_d = e1_data_q;
      end
      2'b11: begin
        // Head leaves, new entry lands behind whatever remains.
        if (cnt_q == 2'd1) begin
          e0_addr_d = b_addr;
          e0_data_d = b_wdata;
        end else begin
          e0_addr_d = e1_addr_q;
          e0_data_d = e1_data_q;
          e1_addr_d = b_addr;
          e1_data_d = b_wdata;
        end
      end
      default: ;
    endcase
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= 2'd0;
      e0_addr_q  <= 5'd0;
      e0_data_q  <= 32'd0;
      e1_addr_q  <= 5'd0;
      e1_data_q  <= 32'd0;
      starve_q   <= 4'd0;
      rf_we_q    <= 1'b0;
      rf_rc_q    <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      cnt_q      <= cnt_d;
      e0_addr_q  <= e0_addr_d;
      e0_data_q  <= e0_data_d;
      e1_addr_q  <= e1_addr_d;
      e1_data_q  <= e1_data_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_rc_q    <= rf_rc_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_RegWrite = rf_we_q;
  assign rf_RegDst   = 2'b00;
  assign rf_rc       = rf_rc_q;
  assign rf_wdata    = rf_wdata_q;

`ifdef REGFILE_ARB_SCOREBOARD_EN
  // Outstanding B destinations; FIFO never holds address 0 so bit 0 stays clear.
  always_comb begin
    pending_mask = 32'd0;
    if (cnt_q != 2'd0) pending_mask[e0_addr_q] = 1'b1;
    if (cnt_q == 2'd2) pending_mask[e1_addr_q] = 1'b1;
  end
`else
  assign pending_mask = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Bench for regfile_wport_arb: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based behavioural model.
module tb_regfile_wport_arb;

  localparam int LIMIT = 4;
`ifdef REGFILE_ARB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [1:0]  a_RegDst, b_RegDst;
  logic [4:0]  a_rb, a_rc, b_rb, b_rc;
  logic [31:0] a_wdata, b_wdata;
  logic        rf_RegWrite;
  logic [1:0]  rf_RegDst;
  logic [4:0]  rf_rc;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;

  always #5 clk = ~clk;

  regfile_wport_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_RegDst(a_RegDst),
    .a_rb(a_rb), .a_rc(a_rc), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_RegDst(b_RegDst),
    .b_rb(b_rb), .b_rc(b_rc), .b_wdata(b_wdata),
    .rf_RegWrite(rf_RegWrite), .rf_RegDst(rf_RegDst), .rf_rc(rf_rc),
    .rf_wdata(rf_wdata), .pending_mask(pending_mask)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [36:0] exp_q[$];   // {addr, data} of buffered B writes, oldest first
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_rc;
  logic [31:0] m_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [4:0] res(input logic [1:0] d, input logic [4:0] rb, input logic [4:0] rc);
    case (d)
      2'b00:   return rc;
      2'b01:   return rb;
      2'b10:   return 5'd31;
      default: return 5'd1;
    endcase
  endfunction

  // One clock cycle: compare at negedge, advance the model, return after posedge.
  task automatic step();
    logic        pop, ar, br, was_empty;
    logic [31:0] mask;
    logic [4:0]  aa, ba;
    @(negedge clk);
    pop = (exp_q.size() > 0) && ((m_starve == LIMIT) || !a_valid);
    ar  = !pop;
    br  = exp_q.size() < 2;
    mask = 32'd0;
    foreach (exp_q[i]) mask[exp_q[i][36:32]] = 1'b1;
    if (!SB) mask = 32'd0;
    chk("a_ready", {31'd0, a_ready}, {31'd0, ar});
    chk("b_ready", {31'd0, b_ready}, {31'd0, br});
    chk("pending_mask", pending_mask, mask);
    chk("rf_RegWrite", {31'd0, rf_RegWrite}, {31'd0, m_we});
    chk("rf_rc", {27'd0, rf_rc}, {27'd0, m_rc});
    chk("rf_wdata", rf_wdata, m_wd);
    chk("rf_RegDst", {30'd0, rf_RegDst}, 32'd0);
    aa = res(a_RegDst, a_rb, a_rc);
    ba = res(b_RegDst, b_rb, b_rc);
    if (reset) begin
      exp_q.delete();
      m_starve = 0; m_we = 1'b0; m_rc = 5'd0; m_wd = 32'd0;
    end else begin
      was_empty = (exp_q.size() == 0);
      m_we = 1'b0; m_rc = 5'd0; m_wd = 32'd0;
      if (pop) begin
        {m_rc, m_wd} = exp_q.pop_front();
        m_we = 1'b1;
        m_starve = 0;
      end else begin
        if (a_valid && aa != 5'd0) begin
          m_we = 1'b1; m_rc = aa; m_wd = a_wdata;
        end
        if (was_empty) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
      end
      if (b_valid && br && ba != 5'd0) exp_q.push_back({ba, b_wdata});
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic v, input logic [1:0] d, input logic [4:0] rb,
                         input logic [4:0] rc, input logic [31:0] wd);
    a_valid = v; a_RegDst = d; a_rb = rb; a_rc = rc; a_wdata = wd;
  endtask

  task automatic drive_b(input logic v, input logic [1:0] d, input logic [4:0] rb,
                         input logic [4:0] rc, input logic [31:0] wd);
    b_valid = v; b_RegDst = d; b_rb = rb; b_rc = rc; b_wdata = wd;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'd0;
    return 5'($urandom_range(1, 31));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int grants;
    reset = 1'b1;
    drive_a(1'b0, 2'b00, 5'd0, 5'd0, 32'd0);
    drive_b(1'b0, 2'b00, 5'd0, 5'd0, 32'd0);
    exp_q.delete();
    m_starve = 0; m_we = 1'b0; m_rc = 5'd0; m_wd = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    step();   // reset still high: reset values compared by the model
    chk("reset_rf_we", {31'd0, rf_RegWrite}, 32'd0);
    chk("reset_b_ready", {31'd0, b_ready}, 32'd1);
    reset = 1'b0;

    // A writes with each RegDst encoding
    drive_a(1'b1, 2'b00, 5'd0, 5'd5, 32'hDEADBEEF);
    #1 chk("a_ready_rc5", {31'd0, a_ready}, 32'd1);
    step();
    chk("a_rc5_we", {31'd0, rf_RegWrite}, 32'd1);
    chk("a_rc5_rc", {27'd0, rf_rc}, 32'd5);
    chk("a_rc5_wd", rf_wdata, 32'hDEADBEEF);
    chk("a_rc5_regdst", {30'd0, rf_RegDst}, 32'd0);
    drive_a(1'b1, 2'b10, 5'd3, 5'd4, 32'h1);
    step();
    chk("a_r31_rc", {27'd0, rf_rc}, 32'd31);
    chk("a_r31_ready", {31'd0, a_ready}, 32'd1);
    drive_a(1'b1, 2'b11, 5'd3, 5'd4, 32'h2);
    step();
    chk("a_r1_rc", {27'd0, rf_rc}, 32'd1);
    drive_a(1'b1, 2'b01, 5'd0, 5'd9, 32'h3);
    #1 chk("a_null_ready", {31'd0, a_ready}, 32'd1);
    step();
    chk("a_null_we", {31'd0, rf_RegWrite}, 32'd0);

    // Starvation guard with a_valid held high
    drive_a(1'b1, 2'b00, 5'd0, 5'd3, 32'hA5A5);
    drive_b(1'b1, 2'b00, 5'd0, 5'd7, 32'h11);
    step();
    drive_b(1'b1, 2'b00, 5'd0, 5'd9, 32'h22);
    #1 chk("starve_first_grant", {31'd0, a_ready}, 32'd1);
    step();
    b_valid = 1'b0;
    chk("b_ready_full", {31'd0, b_ready}, 32'd0);
    grants = 1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!a_ready) break;
      grants++;
      step();
    end
    chk("grants_before_b7", grants, LIMIT);
    step();
    chk("b7_we", {31'd0, rf_RegWrite}, 32'd1);
    chk("b7_rc", {27'd0, rf_rc}, 32'd7);
    chk("b7_wd", rf_wdata, 32'h11);
    grants = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!a_ready) break;
      grants++;
      step();
    end
    chk("grants_before_b9", grants, LIMIT);
    step();
    chk("b9_rc", {27'd0, rf_rc}, 32'd9);
    chk("b9_wd", rf_wdata, 32'h22);

    // pending_mask lifetime for one buffered write
    drive_a(1'b0, 2'b00, 5'd0, 5'd0, 32'd0);
    step();
    drive_b(1'b1, 2'b00, 5'd0, 5'd12, 32'h33);
    step();
    b_valid = 1'b0;
    #1 chk("mask_r12", pending_mask, SB ? 32'h0000_1000 : 32'd0);
    step();
    chk("mask_r12_cleared", pending_mask, 32'd0);
    chk("b12_rc", {27'd0, rf_rc}, 32'd12);

    // Push and pop in the same cycle
    drive_b(1'b1, 2'b00, 5'd0, 5'd20, 32'hA);
    step();
    drive_b(1'b1, 2'b01, 5'd21, 5'd0, 32'hB);
    step();
    b_valid = 1'b0;
    chk("pp_first_rc", {27'd0, rf_rc}, 32'd20);
    chk("pp_b_ready", {31'd0, b_ready}, 32'd1);
    chk("pp_mask", pending_mask, SB ? 32'h0020_0000 : 32'd0);
    step();
    chk("pp_second_rc", {27'd0, rf_rc}, 32'd21);
    chk("pp_second_wd", rf_wdata, 32'hB);

    // Reset with a full FIFO
    drive_a(1'b1, 2'b00, 5'd0, 5'd0, 32'd0);
    drive_b(1'b1, 2'b00, 5'd0, 5'd22, 32'h44);
    step();
    drive_b(1'b1, 2'b00, 5'd0, 5'd23, 32'h55);
    step();
    b_valid = 1'b0;
    chk("rst_full_b_ready", {31'd0, b_ready}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_b_ready", {31'd0, b_ready}, 32'd1);
    chk("rst_mask", pending_mask, 32'd0);
    chk("rst_we", {31'd0, rf_RegWrite}, 32'd0);
    a_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rst_no_stale_write", {31'd0, rf_RegWrite}, 32'd0);
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      drive_a(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_addr(), rand_addr(), $urandom);
      drive_b(($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), rand_addr(), rand_addr(), $urandom);
      step();
    end
    reset = 1'b0;
    drive_a(1'b0, 2'b00, 5'd0, 5'd0, 32'd0);
    drive_b(1'b0, 2'b00, 5'd0, 5'd0, 32'd0);
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
